// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner: synchronises, debounces and edge-detects raw GPIO pad inputs for the AHB GPIO block.
// Optional build macro GPIO_GLITCH_CNT_EN adds GLITCH_CLR / GLITCH_CNT (count of cycles with rejected glitches).
module gpio_in_conditioner #(
    parameter int WIDTH           = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [WIDTH-1:0] GPIOIN,
    input  logic [WIDTH-1:0] EDGE_CLR,
`ifdef GPIO_GLITCH_CNT_EN
    input  logic             GLITCH_CLR,
    output logic [7:0]       GLITCH_CNT,
`endif
    output logic [WIDTH-1:0] GPIOCLEAN,
    output logic [WIDTH-1:0] GPIORISE,
    output logic [WIDTH-1:0] GPIOFALL,
    output logic [WIDTH-1:0] EDGE_STATUS
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] accept;
`ifdef GPIO_GLITCH_CNT_EN
    logic [WIDTH-1:0] reject;
`endif

    // Plain flop chain; no logic between stages so each stage can resolve metastability.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= GPIOIN;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign accept = sync_s ^ GPIOCLEAN;
`ifdef GPIO_GLITCH_CNT_EN
            assign reject = '0;
`endif
        end else begin : g_debounce
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

            // The count is the per-bit state: zero is STABLE, non-zero is COUNTING.
            logic [CNT_W-1:0] cnt_q [WIDTH];

            always_comb begin
                accept = '0;
`ifdef GPIO_GLITCH_CNT_EN
                reject = '0;
`endif
                for (int i = 0; i < WIDTH; i++) begin
                    accept[i] = (sync_s[i] != GPIOCLEAN[i]) && (cnt_q[i] == CNT_MAX);
`ifdef GPIO_GLITCH_CNT_EN
                    reject[i] = (sync_s[i] == GPIOCLEAN[i]) && (cnt_q[i] != '0);
`endif
                end
            end

            always_ff @(posedge HCLK or posedge HRESET) begin
                if (HRESET) begin
                    for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if ((sync_s[i] == GPIOCLEAN[i]) || (cnt_q[i] == CNT_MAX))
                            cnt_q[i] <= '0;
                        else
                            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end
    endgenerate

    // Pulses are registered alongside GPIOCLEAN so they coincide with the new level.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            GPIOCLEAN   <= '0;
            GPIORISE    <= '0;
            GPIOFALL    <= '0;
            EDGE_STATUS <= '0;
        end else begin
            GPIOCLEAN   <= GPIOCLEAN ^ accept;
            GPIORISE    <= accept & ~GPIOCLEAN;
            GPIOFALL    <= accept & GPIOCLEAN;
            EDGE_STATUS <= (EDGE_STATUS & ~EDGE_CLR) | GPIORISE | GPIOFALL;
        end
    end

`ifdef GPIO_GLITCH_CNT_EN
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            GLITCH_CNT <= '0;
        else if (GLITCH_CLR)
            GLITCH_CNT <= '0;
        else if ((|reject) && (GLITCH_CNT != 8'hFF))
            GLITCH_CNT <= GLITCH_CNT + 8'd1;
    end
`endif

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Bench for gpio_in_conditioner: default-debounce instance plus a DEBOUNCE_CYCLES=0 bypass instance.
module tb_gpio_in_conditioner;

    localparam int W    = 16;
    localparam int EV_W = 32 + 3 * W;

    logic         clk;
    logic         rst;
    logic [W-1:0] gpioin;
    logic [W-1:0] edge_clr;
    logic [W-1:0] clean, rise, fall, status;
    logic [W-1:0] gpioin_b;
    logic [W-1:0] edge_clr_b;
    logic [W-1:0] clean_b, rise_b, fall_b, status_b;
`ifdef GPIO_GLITCH_CNT_EN
    logic         glitch_clr;
    logic [7:0]   glitch_cnt;
    logic [7:0]   glitch_cnt_b;
`endif

    int cyc;
    int checks;
    int failures;

    // Expected edge events: {cycle, clean, rise, fall}
    logic [EV_W-1:0] exp_q[$];
    logic [EV_W-1:0] exp_b_q[$];
    logic [EV_W-1:0] e_m;
    logic [EV_W-1:0] e_b;

    gpio_in_conditioner #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .HCLK        (clk),
        .HRESET      (rst),
        .GPIOIN      (gpioin),
        .EDGE_CLR    (edge_clr),
`ifdef GPIO_GLITCH_CNT_EN
        .GLITCH_CLR  (glitch_clr),
        .GLITCH_CNT  (glitch_cnt),
`endif
        .GPIOCLEAN   (clean),
        .GPIORISE    (rise),
        .GPIOFALL    (fall),
        .EDGE_STATUS (status)
    );

    gpio_in_conditioner #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) dut_byp (
        .HCLK        (clk),
        .HRESET      (rst),
        .GPIOIN      (gpioin_b),
        .EDGE_CLR    (edge_clr_b),
`ifdef GPIO_GLITCH_CNT_EN
        .GLITCH_CLR  (glitch_clr),
        .GLITCH_CNT  (glitch_cnt_b),
`endif
        .GPIOCLEAN   (clean_b),
        .GPIORISE    (rise_b),
        .GPIOFALL    (fall_b),
        .EDGE_STATUS (status_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) tick(1);
    endtask

    task automatic push_ev(input int c, input logic [W-1:0] cl, input logic [W-1:0] r,
                           input logic [W-1:0] f);
        exp_q.push_back({c, cl, r, f});
    endtask

    task automatic push_ev_b(input int c, input logic [W-1:0] cl, input logic [W-1:0] r,
                             input logic [W-1:0] f);
        exp_b_q.push_back({c, cl, r, f});
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if ((rise | fall) != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_edge", {rise, fall}, 32'h0);
            end else begin
                e_m = exp_q.pop_front();
                check("ev_cycle", cyc, e_m[EV_W-1 -: 32]);
                check("ev_clean", 32'(clean), 32'(e_m[3*W-1 -: W]));
                check("ev_rise",  32'(rise),  32'(e_m[2*W-1 -: W]));
                check("ev_fall",  32'(fall),  32'(e_m[W-1:0]));
            end
        end
    end

    always @(negedge clk) begin
        if ((rise_b | fall_b) != '0) begin
            if (exp_b_q.size() == 0) begin
                check("byp_unexpected_edge", {rise_b, fall_b}, 32'h0);
            end else begin
                e_b = exp_b_q.pop_front();
                check("byp_ev_cycle", cyc, e_b[EV_W-1 -: 32]);
                check("byp_ev_clean", 32'(clean_b), 32'(e_b[3*W-1 -: W]));
                check("byp_ev_rise",  32'(rise_b),  32'(e_b[2*W-1 -: W]));
                check("byp_ev_fall",  32'(fall_b),  32'(e_b[W-1:0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int c;
        int r;
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        gpioin     = '0;
        edge_clr   = '0;
        gpioin_b   = '0;
        edge_clr_b = '0;
`ifdef GPIO_GLITCH_CNT_EN
        glitch_clr = 1'b0;
`endif
        tick(3);
        check("rst_clean",  32'(clean),  32'h0);
        check("rst_rise",   32'(rise),   32'h0);
        check("rst_fall",   32'(fall),   32'h0);
        check("rst_status", 32'(status), 32'h0);
        check("rst_clean_b", 32'(clean_b), 32'h0);
`ifdef GPIO_GLITCH_CNT_EN
        check("rst_glitch_cnt", 32'(glitch_cnt), 32'h0);
`endif
        rst = 1'b0;
        tick(3);

        // Step on bit 0: visible 7 edges after the first sampling edge.
        c = cyc;
        gpioin = 16'h0001;
        push_ev(c + 7, 16'h0001, 16'h0001, 16'h0000);
        wait_cyc(c + 6);
        check("step_clean_early", 32'(clean), 32'h0000);
        tick(1);
        check("step_clean", 32'(clean), 32'h0001);
        check("step_rise",  32'(rise),  32'h0001);
        tick(1);
        check("step_rise_gone", 32'(rise),   32'h0000);
        check("step_status",    32'(status), 32'h0001);
        tick(2);
        check("step_status_held", 32'(status), 32'h0001);
        edge_clr = 16'hFFFF;
        tick(1);
        edge_clr = '0;
        check("clr_status", 32'(status), 32'h0000);

        // 3-cycle glitch on bit 3 is rejected.
        gpioin = 16'h0009;
        tick(3);
        gpioin = 16'h0001;
        tick(12);
        check("glitch3_clean",  32'(clean),  32'h0001);
        check("glitch3_status", 32'(status), 32'h0000);
`ifdef GPIO_GLITCH_CNT_EN
        check("glitch3_cnt", 32'(glitch_cnt), 32'd1);
`endif

        // 4-cycle pulse on bit 5: one cycle short of acceptance.
        gpioin = 16'h0021;
        tick(4);
        gpioin = 16'h0001;
        tick(12);
        check("glitch4_clean",  32'(clean),  32'h0001);
        check("glitch4_status", 32'(status), 32'h0000);
`ifdef GPIO_GLITCH_CNT_EN
        check("glitch4_cnt", 32'(glitch_cnt), 32'd2);
        glitch_clr = 1'b1;
        tick(1);
        glitch_clr = 1'b0;
        check("glitch_clr_cnt", 32'(glitch_cnt), 32'd0);
`endif

        // 5-cycle pulse on bit 3: minimum accepted width, fall 5 cycles after rise.
        c = cyc;
        gpioin = 16'h0009;
        push_ev(c + 7,  16'h0009, 16'h0008, 16'h0000);
        push_ev(c + 12, 16'h0001, 16'h0000, 16'h0008);
        tick(5);
        gpioin = 16'h0001;
        wait_cyc(c + 12);
        check("minw_fall",  32'(fall),  32'h0008);
        check("minw_clean", 32'(clean), 32'h0001);
        tick(1);
        check("minw_fall_gone", 32'(fall),   32'h0000);
        check("minw_status",    32'(status), 32'h0008);
        edge_clr = 16'hFFFF;
        tick(1);
        edge_clr = '0;
        check("minw_status_clr", 32'(status), 32'h0000);
`ifdef GPIO_GLITCH_CNT_EN
        check("minw_glitch_cnt", 32'(glitch_cnt), 32'd0);
`endif

        // Set/clear race on bit 0: set wins, then a lone clear takes effect.
        c = cyc;
        gpioin = 16'h0000;
        push_ev(c + 7, 16'h0000, 16'h0000, 16'h0001);
        wait_cyc(c + 7);
        check("race_fall", 32'(fall), 32'h0001);
        edge_clr = 16'h0001;
        tick(1);
        check("race_set_wins", 32'(status), 32'h0001);
        tick(1);
        check("race_clear", 32'(status), 32'h0000);
        edge_clr = '0;

        // Multi-bit: put status/low-byte history in place, then reset mid-count.
        c = cyc;
        gpioin = 16'h00FF;
        push_ev(c + 7, 16'h00FF, 16'h00FF, 16'h0000);
        tick(10);
        c = cyc;
        gpioin = 16'h0000;
        push_ev(c + 7, 16'h0000, 16'h0000, 16'h00FF);
        tick(10);
        check("multi_pre_status", 32'(status), 32'h00FF);
        c = cyc;
        gpioin = 16'hFFFF;
        wait_cyc(c + 4);
        rst = 1'b1;
        #1;
        check("midrst_clean",  32'(clean),  32'h0000);
        check("midrst_rise",   32'(rise),   32'h0000);
        check("midrst_fall",   32'(fall),   32'h0000);
        check("midrst_status", 32'(status), 32'h0000);
        tick(2);
        rst = 1'b0;
        r = cyc;
        push_ev(r + 7, 16'hFFFF, 16'hFFFF, 16'h0000);
        wait_cyc(r + 6);
        check("multi_clean_early", 32'(clean), 32'h0000);
        tick(1);
        check("multi_clean", 32'(clean), 32'hFFFF);
        check("multi_rise",  32'(rise),  32'hFFFF);
        tick(1);
        check("multi_rise_gone", 32'(rise),   32'h0000);
        check("multi_status",    32'(status), 32'hFFFF);
        tick(2);

        // Bypass instance: 3 edges from sampling to GPIOCLEAN.
        c = cyc;
        gpioin_b = 16'h00A5;
        push_ev_b(c + 3, 16'h00A5, 16'h00A5, 16'h0000);
        wait_cyc(c + 2);
        check("byp_clean_early", 32'(clean_b), 32'h0000);
        tick(1);
        check("byp_clean", 32'(clean_b), 32'h00A5);
        check("byp_rise",  32'(rise_b),  32'h00A5);
        tick(1);
        check("byp_rise_gone", 32'(rise_b),   32'h0000);
        check("byp_status",    32'(status_b), 32'h00A5);
        tick(3);

        check("exp_q_drained",   exp_q.size(),   32'd0);
        check("exp_b_q_drained", exp_b_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
